// File: rtl/hazard_pkg.sv
// Shared types and constants for the operand-forwarding scoreboard.
package hazard_pkg;

    // Field widths of a scoreboard entry: RV32 register addresses and a
    // result-latency field that covers ALU, load and one extra stage.
    localparam int SB_ADDR_W = 5;
    localparam int SB_LAT_W  = 2;

    // Number of stages after issue before the result sits on a forwarding tap
    localparam logic [SB_LAT_W-1:0] READY_ALU  = SB_LAT_W'(1);
    localparam logic [SB_LAT_W-1:0] READY_LOAD = SB_LAT_W'(2);

    // One in-flight instruction; valid = 0 marks a bubble
    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] rd;
        logic [SB_LAT_W-1:0]  ready_stage;
    } sb_entry_t;

    // Width of a forwarding select: 0 = register file, 1..depth = taps
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-source match, youngest-first priority and forwardability check.
module fwd_match
    import hazard_pkg::*;
#(
    parameter  int DEPTH  = 3,
    parameter  int ADDR_W = 5,
    localparam int SEL_W  = sel_width(DEPTH)
) (
    input  logic                  id_valid,
    input  logic                  src_used,
    input  logic [ADDR_W-1:0]     src_addr,
    input  sb_entry_t [DEPTH-1:0] entries,
    output logic [SEL_W-1:0]      sel,
    output logic                  hazard
);

    logic found;

    // Scan from the youngest entry; the first match decides forward or hazard
    always_comb begin
        // NOTE: combinational blocks use blocking assignments and give every
        // output a default first, so no latch is inferred on any path.
        sel    = '0;
        hazard = 1'b0;
        found  = 1'b0;
        if (id_valid && src_used && (src_addr != '0)) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && entries[k].valid &&
                    (SB_ADDR_W'(src_addr) == entries[k].rd)) begin
                    found = 1'b1;
                    if ((k + 1) >= int'(entries[k].ready_stage)) begin
                        sel = SEL_W'(k + 1);
                    end else begin
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// Operand-forwarding and hazard unit: in-flight history, stall, stall counter.
module forward_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NUM_SRC = 2,
    parameter  int DEPTH   = 3,
    parameter  int ADDR_W  = 5,
    parameter  int LAT_W   = 2,
    parameter  int CNT_W   = 32,
    localparam int SEL_W   = sel_width(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             id_valid,
    input  logic [NUM_SRC-1:0][ADDR_W-1:0]   id_src_addr,
    input  logic [NUM_SRC-1:0]               id_src_used,
    input  logic [ADDR_W-1:0]                id_rd,
    input  logic                             id_reg_write,
    input  logic [LAT_W-1:0]                 id_ready_stage,
    input  logic                             freeze,
    input  logic                             flush,
    output logic [NUM_SRC-1:0][SEL_W-1:0]    fwd_sel,
    output logic                             stall,
    output logic [CNT_W-1:0]                 stall_cnt
);

    // Entry 0 = EXE, 1 = MEM, 2 = WB for the default depth
    sb_entry_t [DEPTH-1:0] sb_q;
    sb_entry_t             issue_entry;
    logic [NUM_SRC-1:0]    src_hazard;

    // One matcher per source operand
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        fwd_match #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_match (
            .id_valid (id_valid),
            .src_used (id_src_used[gi]),
            .src_addr (id_src_addr[gi]),
            .entries  (sb_q),
            .sel      (fwd_sel[gi]),
            .hazard   (src_hazard[gi])
        );
    end

    // A flushed instruction is discarded, so it can never hold the pipeline
    always_comb begin
        stall = (|src_hazard) && !flush;
    end

    // Build the entry that enters EXE; x0 writes and non-writers become bubbles
    always_comb begin
        issue_entry = '0;
        if (id_valid && !stall && !flush && id_reg_write && (id_rd != '0)) begin
            issue_entry.valid       = 1'b1;
            issue_entry.rd          = SB_ADDR_W'(id_rd);
            issue_entry.ready_stage = (id_ready_stage == '0) ? READY_ALU
                                                              : SB_LAT_W'(id_ready_stage);
        end
    end

    // Advance the in-flight history unless the whole pipeline is frozen
    always_ff @(posedge clk) begin
        // NOTE: the history is a handful of flops, not a RAM, so the whole
        // array is reset; stale valid bits would otherwise forward garbage.
        if (rst) begin
            sb_q <= '0;
        end else if (!freeze) begin
            // NOTE: non-blocking assignments let every entry shift from its
            // old neighbour regardless of statement order.
            for (int k = DEPTH - 1; k >= 1; k--) begin
                sb_q[k] <= sb_q[k-1];
            end
            sb_q[0] <= issue_entry;
        end
    end

    // Saturating count of cycles in which the stall actually took effect
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && !freeze && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed scoreboard bench for forward_scoreboard.
module tb_forward_scoreboard;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [1:0][4:0]  id_src_addr;
    logic [1:0]       id_src_used;
    logic [4:0]       id_rd;
    logic             id_reg_write;
    logic [1:0]       id_ready_stage;
    logic             freeze;
    logic             flush;

    logic [1:0][1:0]  fwd_sel;
    logic             stall;
    logic [31:0]      stall_cnt;
    logic [1:0][1:0]  fwd_sel_s;
    logic             stall_s;
    logic [1:0]       stall_cnt_s;

    typedef struct {
        string      name;
        logic [1:0] sel0;
        logic [1:0] sel1;
        logic       stall;
        bit         chk_cnt;
        int         cnt;
        int         cnt_s;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    forward_scoreboard #(
        .NUM_SRC(2), .DEPTH(3), .ADDR_W(5), .LAT_W(2), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_ready_stage(id_ready_stage), .freeze(freeze), .flush(flush),
        .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy used only to observe saturation
    forward_scoreboard #(
        .NUM_SRC(2), .DEPTH(3), .ADDR_W(5), .LAT_W(2), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_ready_stage(id_ready_stage), .freeze(freeze), .flush(flush),
        .fwd_sel(fwd_sel_s), .stall(stall_s), .stall_cnt(stall_cnt_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: compares the DUT against the oldest pending expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".sel0"}, 32'(fwd_sel[0]), 32'(e.sel0));
            check({e.name, ".sel1"}, 32'(fwd_sel[1]), 32'(e.sel1));
            check({e.name, ".stall"}, 32'(stall), 32'(e.stall));
            if (e.chk_cnt) begin
                check({e.name, ".cnt"}, stall_cnt, 32'(e.cnt));
                check({e.name, ".cnt_sat"}, 32'(stall_cnt_s), 32'(e.cnt_s));
            end
        end
    end

    // Apply one ID-stage cycle, optionally queue its expected outputs
    task automatic cyc(input string name, input logic v, input logic [4:0] s0,
                       input logic [4:0] s1, input logic [1:0] used,
                       input logic [4:0] rd, input logic we, input logic [1:0] rs,
                       input logic frz, input logic fl, input bit chk,
                       input logic [1:0] e_sel0, input logic [1:0] e_sel1,
                       input logic e_stall, input bit chk_cnt,
                       input int e_cnt, input int e_cnt_s);
        exp_t e;
        id_valid       = v;
        id_src_addr[0] = s0;
        id_src_addr[1] = s1;
        id_src_used    = used;
        id_rd          = rd;
        id_reg_write   = we;
        id_ready_stage = rs;
        freeze         = frz;
        flush          = fl;
        if (chk) begin
            e.name    = name;
            e.sel0    = e_sel0;
            e.sel1    = e_sel1;
            e.stall   = e_stall;
            e.chk_cnt = chk_cnt;
            e.cnt     = e_cnt;
            e.cnt_s   = e_cnt_s;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Producer with no checked reads
    task automatic prod(input logic [4:0] rd, input logic [1:0] rs);
        cyc("prod", 1, 0, 0, 2'b00, rd, 1, rs, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc("idle", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        id_valid = 0; id_src_addr = '0; id_src_used = '0; id_rd = '0;
        id_reg_write = 0; id_ready_stage = '0; freeze = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        cyc("reset", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);

        // ALU producer x5, then consumers at EXE, MEM, WB taps and after
        cyc("alu_prod",   1, 1, 2, 2'b11, 5, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("alu_fwd_e0", 1, 5, 6, 2'b11, 8, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        cyc("alu_fwd_e1", 1, 9, 5, 2'b11, 0, 0, 1, 0, 0, 1, 0, 2, 0, 0, 0, 0);
        cyc("fwd_e2",     1, 5, 0, 2'b01, 0, 0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        cyc("rf_after",   1, 5, 8, 2'b11, 0, 0, 1, 0, 0, 1, 0, 3, 0, 0, 0, 0);
        idle(3);

        // Load-use: one stall cycle, then MEM tap
        cyc("load_prod", 1, 0, 0, 2'b00, 7, 1, 2, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        cyc("load_use",  1, 1, 7, 2'b11, 9, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0);
        cyc("load_fwd",  1, 1, 7, 2'b11, 9, 1, 1, 0, 0, 1, 0, 2, 0, 1, 1, 1);
        idle(3);

        // x0 is never tracked; unused sources never match
        cyc("x0_prod",    1, 0, 0, 2'b00, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("x0_read",    1, 0, 0, 2'b11, 4, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("unused_src", 1, 4, 4, 2'b00, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("used_src",   1, 4, 0, 2'b01, 0, 0, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0);
        idle(3);

        // Youngest ALU producer wins over older one
        prod(3, 1); prod(10, 1); prod(3, 1);
        cyc("youngest", 1, 3, 0, 2'b01, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        idle(3);

        // Youngest is a load: stall although an older copy is forwardable
        prod(3, 1); prod(11, 1); prod(3, 2);
        cyc("young_load",     1, 0, 3, 2'b10, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1);
        cyc("young_load_fwd", 1, 0, 3, 2'b10, 0, 0, 1, 0, 0, 1, 0, 2, 0, 1, 2, 2);
        idle(3);

        // Load-use held by freeze: stall stays, nothing shifts, count held
        prod(7, 2);
        for (int i = 0; i < 4; i++)
            cyc("freeze_hold", 1, 7, 0, 2'b01, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 2, 2);
        cyc("freeze_rel", 1, 7, 0, 2'b01, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 2, 2);
        cyc("freeze_fwd", 1, 7, 0, 2'b01, 0, 0, 1, 0, 0, 1, 2, 0, 0, 1, 3, 3);
        idle(3);

        // Latency 3: two stall cycles, WB tap; narrow counter saturates at 3
        prod(12, 3);
        cyc("lat3_e0", 1, 12, 0, 2'b01, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 3, 3);
        cyc("lat3_e1", 1, 12, 0, 2'b01, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 4, 3);
        cyc("lat3_e2", 1, 12, 0, 2'b01, 0, 0, 1, 0, 0, 1, 3, 0, 0, 1, 5, 3);
        idle(3);

        // Flush with hazard: no stall, and the flushed writer becomes a bubble
        prod(7, 2);
        cyc("flush_hazard", 1, 7, 0, 2'b01, 7, 1, 1, 0, 1, 1, 0, 0, 0, 1, 5, 3);
        cyc("flush_bubble", 1, 7, 0, 2'b01, 0, 0, 1, 0, 0, 1, 2, 0, 0, 1, 5, 3);
        idle(3);

        // ready_stage 0 behaves as an ALU result
        prod(13, 0);
        cyc("ready0_fwd", 1, 13, 0, 2'b01, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        idle(3);

        // Reset during a frozen hazard clears everything
        prod(7, 2);
        rst = 1'b1;
        cyc("rst_mid_hazard", 1, 7, 0, 2'b01, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 5, 3);
        rst = 1'b0;
        cyc("post_rst", 1, 7, 0, 2'b01, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/forward_scoreboard.md
# forward_scoreboard

Parametrised operand-forwarding and hazard unit for the in-order RISC-V pipeline, sitting beside the ID stage. It tracks the destination register and result-ready stage of every in-flight instruction in a DEPTH-entry shift register. Each cycle it chooses a forwarding tap for each of NUM_SRC source operands of the instruction in ID. When the youngest producer's value does not yet exist at any tap, it raises a load-use style stall. Unlike the previous combinational two-stage forwarding logic, it holds its own pipeline history, handles multi-cycle result latency, and counts stall cycles.

## Interface
Parameters:
- NUM_SRC, 2, number of source operands checked per issuing instruction
- DEPTH, 3, tracked stages after ID (entry 0 = EXE, 1 = MEM, 2 = WB)
- ADDR_W, 5, register address width
- LAT_W, 2, width of the ready-stage field
- CNT_W, 32, stall counter width

Ports (clock and reset first):
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction this cycle
- id_src_addr  in  NUM_SRC×ADDR_W  source register addresses of the ID instruction
- id_src_used  in  NUM_SRC  per-source: operand actually read
- id_rd  in  ADDR_W  destination of the ID instruction
- id_reg_write  in  1  ID instruction writes rd
- id_ready_stage  in  LAT_W  stages after issue until the result exists at a tap (1 = ALU, 2 = load); 0 is treated as 1
- freeze  in  1  whole-pipeline hold (memory wait)
- flush  in  1  kill the ID instruction (branch redirect)
- fwd_sel  out  NUM_SRC×$clog2(DEPTH+1)  per source: 0 = register file, k+1 = tap of entry k
- stall  out  1  hold IF/ID and inject a bubble into EXE
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Each entry holds valid, rd, and ready_stage. rd is recorded only when reg_write is set and rd != 0; otherwise the entry is a bubble.
- Match rule: entry k matches source i when id_valid, id_src_used[i], the entry is valid, src_addr[i] != 0, and src_addr[i] == rd.
- Priority: the youngest (lowest k) matching entry wins. Older matches are ignored.
- Forwardability: the winning entry is forwardable iff k+1 >= ready_stage.
  - Forwardable → fwd_sel[i] = k+1.
  - Not forwardable → fwd_sel[i] = 0 and the source is hazarded.
  - No match → fwd_sel[i] = 0.
- stall = OR of hazarded sources, gated by !flush. A flushed instruction never stalls.
- Shift on each clock edge, unless freeze:
  - entry[k] ← entry[k-1] for k ≥ 1.
  - entry[0] ← ID instruction if id_valid & !stall & !flush; otherwise a bubble.
- freeze: no entry changes. Outputs stay combinationally valid. stall_cnt does not increment.
- stall_cnt increments on cycles with stall & !freeze and saturates at all-ones.
- fwd_sel and stall are combinational from registered state and ID inputs. Zero-cycle latency.

## Timing
- Reset (synchronous): all entries invalid and stall_cnt = 0. Therefore fwd_sel = 0 and stall = 0 from the first cycle after reset.
- Reset during a stall or freeze clears everything on that edge; reset wins over freeze and flush.
- ALU producer at cycle t, consumer in ID at t+1: fwd_sel = 1, no stall.
- Load producer at cycle t, consumer at t+1:
  - stall for 1 cycle (bubble enters entry 0);
  - at t+2 the load is in entry 1 and fwd_sel = 2.
- A producer at entry DEPTH-1 forwards with sel = DEPTH. After it leaves, the register file (write-through) supplies the value with sel = 0.
- freeze and stall in the same cycle: freeze wins, no shift, counter held, stall still asserted.
- flush and hazard in the same cycle: stall = 0 and a bubble is inserted.

## Structure
- Shared package `hazard_pkg`:
  - sb_entry_t struct (valid, rd, ready_stage);
  - SEL_W localparam function ($clog2(DEPTH+1));
  - READY_ALU = 1 and READY_LOAD = 2 constants.
- Sub-module `fwd_match`: one source's match, priority encoding, and forwardability over all entries. Outputs sel and hazard. Instantiated NUM_SRC times via generate.
- The top level holds the entry shift register, stall OR, and counter.

## Test plan
- ALU writes x5, next instruction reads x5 on src0 → fwd_sel[0] = 1, stall = 0. Two cycles later reading x5 → sel = 2.
- Load writes x7, next instruction reads x7 on src1 → stall = 1 for exactly one cycle, then sel[1] = 2; stall_cnt = 1.
- Producer writes x0, consumer reads x0 → sel = 0, no stall. Same for a read with src_used = 0.
- x3 written at entries 0 and 2 (ALU) → sel = 1 (youngest). Youngest is a load at entry 0 → stall, even though entry 2 is forwardable.
- Load-use hazard with freeze held 4 cycles → stall stays high, entries frozen, stall_cnt unchanged. After release: one stall cycle, then sel = 2.
- Reset asserted mid-hazard → next cycle stall = 0, all sel = 0, stall_cnt = 0. With CNT_W = 2 forced to 3, a further stall keeps the count at 3.
